// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_receiver and uart_transmitter.
package uart_pkg;

  localparam int unsigned UART_CLOCKS_PER_BIT = 434;
  localparam int unsigned UART_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } uart_rx_state_t;

endpackage

// File: rtl/uart_receiver_fifo.sv
// Synchronous show-ahead FIFO for the UART receive buffer.
// Pointers carry an extra MSB so full and empty can be told apart.
module uart_receiver_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_pop;
  logic                do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full is still accepted.
  assign do_push = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling, receive buffer and sticky error flags.
// Define UART_RECEIVER_FIFO_EN for a 2**FIFO_DEPTH_LOG2 FIFO; otherwise a single holding register.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT  = UART_CLOCKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] read_data,
  output logic                      read_data_valid,
  input  logic                      read_req,
  output logic                      framing_error,
  output logic                      overrun,
  input  logic                      clear_errors
);

  localparam int unsigned      CNT_W     = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned      IDX_W     = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_meta;
  logic                      rx_s;
  uart_rx_state_t            state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      sample_now;
  logic                      push;
  logic                      frame_bad;
  logic                      pop;
  logic                      buf_full;
  logic                      overrun_set;
  logic [UART_DATA_BITS-1:0] head_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign sample_now = (bit_cnt == '0);
  // Push and error are decided on the stop-sample edge so the buffer and flags update the next cycle.
  assign push      = (state == RX_STOP) && sample_now && rx_s;
  assign frame_bad = (state == RX_STOP) && sample_now && !rx_s;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            bit_cnt <= HALF_LOAD;
            state   <= RX_START;
          end
        end
        RX_START: begin
          if (sample_now) begin
            if (rx_s) begin
              state <= RX_IDLE;
            end else begin
              bit_cnt <= FULL_LOAD;
              bit_idx <= '0;
              state   <= RX_DATA;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (sample_now) begin
            shift_reg[bit_idx] <= rx_s;
            bit_cnt            <= FULL_LOAD;
            bit_idx            <= bit_idx + IDX_W'(1);
            if (bit_idx == LAST_IDX) state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (sample_now) begin
            state <= rx_s ? RX_IDLE : RX_RECOVER;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        RX_RECOVER: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign pop         = read_req && read_data_valid;
  assign overrun_set = push && buf_full && !pop;

`ifdef UART_RECEIVER_FIFO_EN
  logic fifo_empty;

  uart_receiver_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shift_reg),
    .pop       (pop),
    .pop_data  (head_data),
    .empty     (fifo_empty),
    .full      (buf_full)
  );

  assign read_data_valid = !fifo_empty;
`else
  logic                      hold_valid;
  logic [UART_DATA_BITS-1:0] hold_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= shift_reg;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full        = hold_valid;
  assign head_data       = hold_data;
  assign read_data_valid = hold_valid;
`endif

  // Stale FIFO contents are masked so read_data reads 0 whenever the buffer is empty.
  assign read_data = read_data_valid ? head_data : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (frame_bad)         framing_error <= 1'b1;
      else if (clear_errors) framing_error <= 1'b0;
      if (overrun_set)       overrun       <= 1'b1;
      else if (clear_errors) overrun       <= 1'b0;
    end
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, 8N1, LSB first; the receive-side counterpart of `uart_transmitter`. It sits beside `uart_transmitter` and behind a future bus interface block, which polls `read_data_valid` and pops bytes with `read_req`. It includes:
- a 2-flop input synchronizer;
- a mid-bit sampling state machine;
- a receive buffer;
- sticky framing-error and overrun flags.

## Interface
Parameters:
- `CLOCKS_PER_BIT`, default 434 (50 MHz / 115200): clk cycles per serial bit. Must be ≥ 4.
- `FIFO_DEPTH_LOG2`, default 3: log2 of receive FIFO depth. Only used when `UART_RECEIVER_FIFO_EN` is defined.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  **synchronous, active-low** reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `read_data`  out  8  head byte of the buffer. Valid whenever `read_data_valid` is 1 (show-ahead).
- `read_data_valid`  out  1  buffer is non-empty.
- `read_req`  in  1  pop the head byte. Ignored when the buffer is empty.
- `framing_error`  out  1  sticky: a stop bit was sampled as 0.
- `overrun`  out  1  sticky: a byte arrived while the buffer was full.
- `clear_errors`  in  1  clears both sticky flags.

## Operation
- **Synchronizer:** `rx` passes through two flops, both reset to 1. Call the output `rx_s`. The FSM sees only `rx_s`.
- **Counters:** one bit counter (`$clog2(CLOCKS_PER_BIT)` bits) and a 3-bit bit index.
- **FSM states:** IDLE, START, DATA, STOP, RECOVER.
  - **IDLE:** when `rx_s` == 0, load counter = `CLOCKS_PER_BIT/2 - 1` (floor) and go to START.
  - **START:** at counter 0, resample `rx_s`.
    - If 1 (glitch), go to IDLE; nothing is pushed and no flag is set.
    - If 0, load counter = `CLOCKS_PER_BIT-1`, clear the bit index, and go to DATA.
  - **DATA:** at counter 0, shift `rx_s` into bit [index] (LSB first) and reload the counter. After index 7, go to STOP.
  - **STOP:** at counter 0, sample `rx_s`.
    - If 1, push the byte and go to IDLE immediately (mid stop bit), so back-to-back frames are supported.
    - If 0, set `framing_error`, discard the byte, and go to RECOVER.
  - **RECOVER:** wait for `rx_s` == 1, then go to IDLE. A held-low break therefore yields exactly one framing error.
- **Buffer push while full:** the new byte is dropped, the stored bytes are unchanged, and `overrun` is set.
- **Simultaneous push and pop:**
  - When full: the pop is performed, the push is accepted, and no overrun occurs.
  - When empty: the push is accepted and the buffer is non-empty afterwards.
- **Flag priority:** a flag set and `clear_errors` in the same cycle leaves the flag at 1 (set wins).
- **Reset values:** all outputs 0. The FSM returns to IDLE, the buffer empties, and the synchronizer flops go to 1. Reset mid-frame abandons the frame with no push and no flag.

## Timing
- Let t0 be the first cycle the FSM sees `rx_s` == 0. This is 2–3 clk after the pin falls, due to the synchronizer.
- Start bit is resampled at t0 + `CLOCKS_PER_BIT/2`.
- Data bit i is sampled at t0 + `CLOCKS_PER_BIT/2` + (i+1)·`CLOCKS_PER_BIT`.
- Stop bit is sampled at t0 + `CLOCKS_PER_BIT/2` + 9·`CLOCKS_PER_BIT`.
- `read_data_valid` rises, and the flags update, on the cycle after the stop sample.
- A pop takes effect in the cycle `read_req` is high while `read_data_valid` is 1. `read_data` and `read_data_valid` reflect the next entry on the following cycle.
- Throughput: one byte per 10·`CLOCKS_PER_BIT` cycles sustained. The consumer may pop every cycle.

## Configuration
- **`UART_RECEIVER_FIFO_EN` defined:** the buffer is a 2^`FIFO_DEPTH_LOG2`-entry FIFO.
  - Read/write pointers are `FIFO_DEPTH_LOG2`+1 bits wide, with MSB wrap for the full/empty distinction.
  - "Full" means all entries are occupied.
- **`UART_RECEIVER_FIFO_EN` undefined:** the buffer is a single holding register plus a valid bit. "Full" means the valid bit is set.
- All other behaviour is identical in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - the receiver state enum (`uart_rx_state_t`);
  - the default `CLOCKS_PER_BIT` constant, also used by `uart_transmitter`;
  - constants for the data-bit count (8).
- One sub-module, `uart_receiver_fifo` (synchronous FIFO, show-ahead). It is instantiated only under `UART_RECEIVER_FIFO_EN`; the single-register path is inline.

## Test plan
Run with `CLOCKS_PER_BIT`=16.
- **Single frame:** drive 0x5A as a clean frame → `read_data`=0x5A, `read_data_valid` rises at t0+8+144+1, flags stay 0. Pulse `read_req` → valid drops next cycle.
- **Glitch:** drive a 6-cycle low pulse on `rx` → no push, no flag, FSM back in IDLE; a following 0xA5 frame is received correctly.
- **Framing error:** send 0x33 with the stop bit held low for 3 bit times → `framing_error`=1, nothing pushed, one error only. Then pulse `clear_errors` → 0.
- **Overrun:** send back-to-back frames 0x01..0x0A with no pops.
  - FIFO build (depth 8): 0x01..0x08 retained in order and `overrun`=1.
  - Register build: 0x01 retained and `overrun`=1.
- **Simultaneous events:**
  - Assert `read_req` in the push cycle when full → no overrun.
  - Assert `clear_errors` in the framing-error set cycle → flag=1.
- **Reset mid-frame:** assert `reset_n`=0 for 1 cycle after data bit 3 of 0xFF → no push, all outputs 0; the next frame 0x81 is received intact.
